// File: rtl/mc_pkg.sv
// mc_pkg: shared states, class indices, trap causes and PC source codes for the multicycle controller
package mc_pkg;
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_MEM_ADDR, S_MEM_READ,
    S_MEM_WRITE, S_WB, S_BRANCH, S_JUMP, S_TRAP
  } state_t;
  localparam int CLS_R  = 0;
  localparam int CLS_B1 = 1;
  localparam int CLS_J  = 2;
  localparam int CLS_B2 = 3;
  localparam int CLS_I  = 4;
  localparam int CLS_F  = 5;
  localparam int CLS_M  = 6;
  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_FP      = 2'b10;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b11;
  localparam logic [1:0] PC_SEQ    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_EXC    = 2'b11;
  localparam int WAIT_LIMIT = 16;
  function automatic logic is_onehot(input logic [6:0] v);
    return (v != '0) && ((v & (v - 7'd1)) == '0);
  endfunction
endpackage

// File: rtl/mc_wait_timer.sv
// mc_wait_timer: counts consecutive wait cycles and flags the last allowed one
module mc_wait_timer
  import mc_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  logic [3:0] r_cnt;
  always_ff @(posedge clk or posedge reset)
    if (reset) r_cnt <= '0;
    else if (clear) r_cnt <= '0;
    else if (enable) r_cnt <= r_cnt + 4'd1;
  assign expired = enable && (r_cnt == 4'(WAIT_LIMIT - 1));
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: multicycle instruction sequencer with bus timeout and sticky trap
module multicycle_controller
  import mc_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  cls,
  input  logic        op3,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  input  logic        branch_taken,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic        alu_src_b,
  output logic        rf_we,
  output logic        mem_re,
  output logic        mem_we,
  output logic        trap,
  output logic [1:0]  trap_cause,
  output logic [3:0]  state,
  output logic [15:0] instr_retired
);
  state_t      r_state, w_next;
  logic [1:0]  r_cause, w_cause;
  logic        r_trap;
  logic [15:0] r_retired;
  logic        w_wait_en, w_expired, w_retire;
  assign w_wait_en = r_state inside {S_FETCH, S_MEM_READ, S_MEM_WRITE};
  assign w_retire  = (w_next == S_FETCH) && (r_state inside {S_WB, S_MEM_WRITE, S_BRANCH, S_JUMP});
  mc_wait_timer u_timer (
    .clk(clk), .reset(reset), .clear(w_next != r_state), .enable(w_wait_en), .expired(w_expired)
  );
  always_comb begin
    w_next = r_state;
    w_cause = r_cause;
    ir_we = 1'b0;
    pc_we = 1'b0;
    pc_src = PC_SEQ;
    alu_src_b = 1'b0;
    rf_we = 1'b0;
    mem_re = 1'b0;
    mem_we = 1'b0;
    case (r_state)
      S_FETCH: begin
        ir_we = imem_ready & ~reset;
        pc_we = imem_ready & ~reset;
        if (imem_ready) w_next = S_DECODE;
        else if (w_expired) begin
          w_next = S_TRAP;
          w_cause = CAUSE_TIMEOUT;
        end
      end
      S_DECODE: begin
        if (!is_onehot(cls)) begin
          w_next = S_TRAP;
          w_cause = CAUSE_ILLEGAL;
        end else if (cls[CLS_F]) begin
          w_next = S_TRAP;
          w_cause = CAUSE_FP;
        end else
          w_next = cls[CLS_R] ? S_EXEC_R :
                   cls[CLS_I] ? S_EXEC_I :
                   cls[CLS_M] ? S_MEM_ADDR :
                   (cls[CLS_B1] | cls[CLS_B2]) ? S_BRANCH : S_JUMP;
      end
      S_EXEC_R: w_next = S_WB;
      S_EXEC_I: begin
        alu_src_b = 1'b1;
        w_next = S_WB;
      end
      S_MEM_ADDR: begin
        alu_src_b = 1'b1;
        w_next = op3 ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ, S_MEM_WRITE: begin
        mem_re = (r_state == S_MEM_READ);
        mem_we = (r_state == S_MEM_WRITE);
        if (dmem_ready) w_next = (r_state == S_MEM_READ) ? S_WB : S_FETCH;
        else if (w_expired) begin
          w_next = S_TRAP;
          w_cause = CAUSE_TIMEOUT;
        end
      end
      S_WB: begin
        rf_we = 1'b1;
        w_next = S_FETCH;
      end
      S_BRANCH: begin
        pc_src = PC_BRANCH;
        pc_we = branch_taken;
        w_next = S_FETCH;
      end
      S_JUMP: begin
        pc_src = PC_JUMP;
        pc_we = 1'b1;
        w_next = S_FETCH;
      end
      S_TRAP: begin
        pc_src = PC_EXC;
        pc_we = ~r_trap;
      end
      default: w_next = S_FETCH;
    endcase
  end
  // r_trap rises after the first TRAP cycle, ending the exception-vector pulse
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state <= S_FETCH;
      r_cause <= CAUSE_NONE;
      r_trap <= 1'b0;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      r_cause <= w_cause;
      r_trap <= (r_state == S_TRAP);
      if (w_retire) r_retired <= r_retired + 16'd1;
    end
  assign trap = r_trap;
  assign trap_cause = r_cause;
  assign state = r_state;
  assign instr_retired = r_retired;
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: scoreboard bench driving per-cycle stimulus/expectation entries
module tb_multicycle_controller;
  import mc_pkg::*;
  logic clk = 1'b0, reset = 1'b1;
  logic [6:0] cls = '0;
  logic op3 = 1'b0, imem_ready = 1'b0, dmem_ready = 1'b0, branch_taken = 1'b0;
  logic ir_we, pc_we, alu_src_b, rf_we, mem_re, mem_we, trap;
  logic [1:0] pc_src, trap_cause;
  logic [3:0] state;
  logic [15:0] instr_retired;
  int n_err = 0, n_chk = 0;
  always #5 clk = ~clk;
  multicycle_controller dut (
    .clk(clk), .reset(reset), .cls(cls), .op3(op3), .imem_ready(imem_ready),
    .dmem_ready(dmem_ready), .branch_taken(branch_taken), .ir_we(ir_we), .pc_we(pc_we),
    .pc_src(pc_src), .alu_src_b(alu_src_b), .rf_we(rf_we), .mem_re(mem_re), .mem_we(mem_we),
    .trap(trap), .trap_cause(trap_cause), .state(state), .instr_retired(instr_retired)
  );
  typedef struct packed {
    logic im;
    logic dm;
    logic bt;
    state_t st;
    logic [7:0] sv;
  } ent_t;
  ent_t q[$];
  localparam logic [7:0] SV_NONE  = 8'b0000_0000;
  localparam logic [7:0] SV_FETCH = 8'b1100_0000;
  localparam logic [7:0] SV_ALU   = 8'b0000_1000;
  localparam logic [7:0] SV_RD    = 8'b0000_0010;
  localparam logic [7:0] SV_WR    = 8'b0000_0001;
  localparam logic [7:0] SV_WB    = 8'b0000_0100;
  localparam logic [7:0] SV_BR_T  = 8'b0101_0000;
  localparam logic [7:0] SV_BR_N  = 8'b0001_0000;
  localparam logic [7:0] SV_JMP   = 8'b0110_0000;
  localparam logic [7:0] SV_TRAP  = 8'b0111_0000;
  task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  task automatic put(input logic im, input logic dm, input logic bt, input state_t st, input logic [7:0] sv);
    q.push_back('{im: im, dm: dm, bt: bt, st: st, sv: sv});
  endtask
  task automatic fetch_dec();
    put(1'b1, 1'b1, 1'b0, S_FETCH, SV_FETCH);
    put(1'b1, 1'b1, 1'b0, S_DECODE, SV_NONE);
  endtask
  task automatic drain();
    ent_t e;
    while (q.size() > 0) begin
      e = q.pop_front();
      imem_ready = e.im;
      dmem_ready = e.dm;
      branch_taken = e.bt;
      #1;
      check("state", 16'(state), 16'(e.st));
      check("strobes", 16'({ir_we, pc_we, pc_src, alu_src_b, rf_we, mem_re, mem_we}), 16'(e.sv));
      check("excl", 16'($countones({rf_we, mem_re, mem_we}) < 2), 16'd1);
      @(posedge clk);
      #1;
    end
  endtask
  task automatic hold_trap(input logic [1:0] cause);
    imem_ready = 1'b1;
    dmem_ready = 1'b1;
    branch_taken = 1'b1;
    for (int i = 0; i < 50; i++) begin
      #1;
      check("trap_state", 16'(state), 16'(S_TRAP));
      check("trap_flag", 16'(trap), 16'd1);
      check("trap_cause", 16'(trap_cause), 16'(cause));
      check("trap_quiet", 16'({ir_we, pc_we, rf_we, mem_re, mem_we}), 16'd0);
      @(posedge clk);
      #1;
    end
  endtask
  logic [6:0] bad_cls[3];
  logic [1:0] bad_cause[3];
  initial begin
    bad_cls = '{7'b0000000, 7'b0000011, 7'b0100000};
    bad_cause = '{2'b01, 2'b01, 2'b10};
    imem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", 16'(state), 16'(S_FETCH));
    check("rst_strobes", 16'({ir_we, pc_we, pc_src, alu_src_b, rf_we, mem_re, mem_we}), 16'd0);
    check("rst_retired", instr_retired, 16'd0);
    check("rst_trap", 16'({trap, trap_cause}), 16'd0);
    reset = 1'b0;
    cls = 7'b0000001;
    fetch_dec();
    put(1, 1, 0, S_EXEC_R, SV_NONE);
    put(1, 1, 0, S_WB, SV_WB);
    drain();
    check("ret_r", instr_retired, 16'd1);
    cls = 7'b0010000;
    fetch_dec();
    put(1, 1, 0, S_EXEC_I, SV_ALU);
    put(1, 1, 0, S_WB, SV_WB);
    drain();
    check("ret_i", instr_retired, 16'd2);
    cls = 7'b1000000;
    op3 = 1'b0;
    fetch_dec();
    put(1, 1, 0, S_MEM_ADDR, SV_ALU);
    for (int i = 0; i < 3; i++) put(1, 0, 0, S_MEM_READ, SV_RD);
    put(1, 1, 0, S_MEM_READ, SV_RD);
    put(1, 1, 0, S_WB, SV_WB);
    drain();
    check("ret_load", instr_retired, 16'd3);
    op3 = 1'b1;
    fetch_dec();
    put(1, 1, 0, S_MEM_ADDR, SV_ALU);
    put(1, 1, 0, S_MEM_WRITE, SV_WR);
    drain();
    check("ret_store", instr_retired, 16'd4);
    cls = 7'b0000010;
    fetch_dec();
    put(1, 1, 1, S_BRANCH, SV_BR_T);
    drain();
    check("ret_br_t", instr_retired, 16'd5);
    fetch_dec();
    put(1, 1, 0, S_BRANCH, SV_BR_N);
    drain();
    check("ret_br_n", instr_retired, 16'd6);
    cls = 7'b0001000;
    fetch_dec();
    put(1, 1, 1, S_BRANCH, SV_BR_T);
    drain();
    cls = 7'b0000100;
    fetch_dec();
    put(1, 1, 0, S_JUMP, SV_JMP);
    drain();
    check("ret_jump", instr_retired, 16'd8);
    cls = 7'b0000001;
    for (int i = 0; i < 15; i++) put(0, 1, 0, S_FETCH, SV_NONE);
    fetch_dec();
    put(1, 1, 0, S_EXEC_R, SV_NONE);
    put(1, 1, 0, S_WB, SV_WB);
    drain();
    check("ret_fetch_wait", instr_retired, 16'd9);
    cls = 7'b1000000;
    op3 = 1'b1;
    fetch_dec();
    put(1, 1, 0, S_MEM_ADDR, SV_ALU);
    for (int i = 0; i < 15; i++) put(1, 0, 0, S_MEM_WRITE, SV_WR);
    put(1, 1, 0, S_MEM_WRITE, SV_WR);
    drain();
    check("ret_store_wait", instr_retired, 16'd10);
    force dut.r_retired = 16'hFFFF;
    #1;
    release dut.r_retired;
    #1;
    check("preload", instr_retired, 16'hFFFF);
    cls = 7'b0000100;
    fetch_dec();
    put(1, 1, 0, S_JUMP, SV_JMP);
    drain();
    check("ret_wrap", instr_retired, 16'h0000);
    fetch_dec();
    put(1, 1, 0, S_JUMP, SV_JMP);
    drain();
    check("ret_after_wrap", instr_retired, 16'h0001);
    cls = 7'b1000000;
    op3 = 1'b0;
    fetch_dec();
    put(1, 1, 0, S_MEM_ADDR, SV_ALU);
    put(1, 0, 0, S_MEM_READ, SV_RD);
    drain();
    reset = 1'b1;
    #1;
    check("rst_mid_state", 16'(state), 16'(S_FETCH));
    check("rst_mid_mem_re", 16'(mem_re), 16'd0);
    check("rst_mid_retired", instr_retired, 16'd0);
    #2;
    reset = 1'b0;
    for (int i = 0; i < 16; i++) put(0, 0, 0, S_FETCH, SV_NONE);
    put(0, 0, 0, S_TRAP, SV_TRAP);
    drain();
    hold_trap(2'b11);
    check("ret_timeout", instr_retired, 16'd0);
    for (int k = 0; k < 3; k++) begin
      reset = 1'b1;
      #3;
      reset = 1'b0;
      cls = 7'b0000001;
      fetch_dec();
      put(1, 1, 0, S_EXEC_R, SV_NONE);
      put(1, 1, 0, S_WB, SV_WB);
      drain();
      cls = bad_cls[k];
      fetch_dec();
      put(1, 1, 0, S_TRAP, SV_TRAP);
      drain();
      hold_trap(bad_cause[k]);
      check("ret_trapped", instr_retired, 16'd1);
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
